// File: rtl/simmem_bank_timing_model_pkg.sv
// Shared constants and bank state encoding for the multi-bank DRAM timing model.
package simmem_bank_timing_model_pkg;

    // Default geometry of the simulated memory
    localparam int DefNumBanks      = 4;
    localparam int GlobalMemCapaW   = 16;
    localparam int DefRowBufLenW    = 8;
    localparam int RDataBankAddrW   = 4;

    // Default DRAM cost constants, in cycles
    localparam int DefRowHitCost     = 4;
    localparam int DefPrechargeCost  = 2;
    localparam int DefActivationCost = 1;
    localparam int DefDelayWidth     = 6;

    // Derived address-field widths for the default geometry
    localparam int DefBankIdxW = $clog2(DefNumBanks);
    localparam int DefRowW     = GlobalMemCapaW - DefRowBufLenW - DefBankIdxW;

    // Per-bank state encoding; plain constants keep older tools happy
    typedef logic [2:0] bank_state_t;
    localparam bank_state_t BankClosed = 3'd0;
    localparam bank_state_t BankOpen   = 3'd1;
    localparam bank_state_t BankActive = 3'd2;
    localparam bank_state_t BankDone   = 3'd3;
    localparam bank_state_t BankPre    = 3'd4;

endpackage

// File: rtl/simmem_bank_timing_model_if.sv
// Request/completion bundle between the memory controller and the timing model.
interface simmem_bank_timing_model_if
    import simmem_bank_timing_model_pkg::*;
#(
    parameter int NumBanks   = DefNumBanks,
    parameter int AddrW      = GlobalMemCapaW,
    parameter int IidW       = RDataBankAddrW,
    parameter int DelayWidth = DefDelayWidth
) ();

    logic                  req_valid_i;
    logic                  req_ready_o;
    logic [AddrW-1:0]      req_addr_i;
    logic [IidW-1:0]       req_iid_i;
    logic                  done_valid_o;
    logic                  done_ready_i;
    logic [IidW-1:0]       done_iid_o;
    logic [DelayWidth-1:0] done_delay_o;
    logic [NumBanks-1:0]   bank_busy_o;

    // Controller side: issues requests and consumes completions
    modport master (
        output req_valid_i, req_addr_i, req_iid_i, done_ready_i,
        input  req_ready_o, done_valid_o, done_iid_o, done_delay_o, bank_busy_o
    );

    // Timing model side
    modport slave (
        input  req_valid_i, req_addr_i, req_iid_i, done_ready_i,
        output req_ready_o, done_valid_o, done_iid_o, done_delay_o, bank_busy_o
    );

endinterface

// File: rtl/simmem_bank_timing_model_tracker.sv
// One DRAM bank: open-row tracking, access cost and completion countdown.
module simmem_bank_timing_model_tracker
    import simmem_bank_timing_model_pkg::*;
#(
    parameter int RowW           = DefRowW,
    parameter int IidW           = RDataBankAddrW,
    parameter int RowHitCost     = DefRowHitCost,
    parameter int PrechargeCost  = DefPrechargeCost,
    parameter int ActivationCost = DefActivationCost,
    parameter int DelayWidth     = DefDelayWidth,
    parameter int ClosedPage     = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  accept_i,
    input  logic [RowW-1:0]       row_i,
    input  logic [IidW-1:0]       iid_i,
    input  logic                  pop_i,
    output logic                  idle_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [IidW-1:0]       iid_o,
    output logic [DelayWidth-1:0] cost_o
);

    localparam logic [DelayWidth-1:0] HitCost  = DelayWidth'(RowHitCost);
    localparam logic [DelayWidth-1:0] ColdCost = DelayWidth'(ActivationCost + RowHitCost);
    localparam logic [DelayWidth-1:0] MissCost = DelayWidth'(PrechargeCost + ActivationCost + RowHitCost);
    localparam logic [DelayWidth-1:0] PreCost  = DelayWidth'(PrechargeCost);

    bank_state_t           state_q, state_d;
    logic [RowW-1:0]       row_q, row_d;
    logic [IidW-1:0]       iid_q, iid_d;
    logic [DelayWidth-1:0] cost_q, cost_d;
    logic [DelayWidth-1:0] cnt_q, cnt_d;
    logic [DelayWidth-1:0] reqCost;

    // Cost of a request arriving now, given the row currently held open
    always_comb begin
        if (ClosedPage != 0 || state_q != BankOpen) begin
            reqCost = ColdCost;
        end else if (row_q == row_i) begin
            reqCost = HitCost;
        end else begin
            reqCost = MissCost;
        end
    end

    // Bank state machine; the counter holds the cycles left before the next state change
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        iid_d   = iid_q;
        cost_d  = cost_q;
        cnt_d   = cnt_q;
        case (state_q)
            BankClosed, BankOpen: begin
                if (accept_i) begin
                    row_d  = row_i;
                    iid_d  = iid_i;
                    cost_d = reqCost;
                    if (reqCost == DelayWidth'(1)) begin
                        state_d = BankDone;
                        cnt_d   = '0;
                    end else begin
                        state_d = BankActive;
                        cnt_d   = reqCost - DelayWidth'(2);
                    end
                end
            end
            BankActive: begin
                if (cnt_q == '0) begin
                    state_d = BankDone;
                end else begin
                    cnt_d = cnt_q - DelayWidth'(1);
                end
            end
            BankDone: begin
                if (pop_i) begin
                    if (ClosedPage == 0) begin
                        state_d = BankOpen;
                    end else if (PrechargeCost == 0) begin
                        state_d = BankClosed;
                    end else begin
                        state_d = BankPre;
                        cnt_d   = PreCost - DelayWidth'(1);
                    end
                end
            end
            BankPre: begin
                if (cnt_q == '0) begin
                    state_d = BankClosed;
                end else begin
                    cnt_d = cnt_q - DelayWidth'(1);
                end
            end
            default: begin
                state_d = BankClosed;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers; reset drops any pending completion and closes the row
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= BankClosed;
            row_q   <= '0;
            iid_q   <= '0;
            cost_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            iid_q   <= iid_d;
            cost_q  <= cost_d;
            cnt_q   <= cnt_d;
        end
    end

    assign idle_o = (state_q == BankClosed) || (state_q == BankOpen);
    assign busy_o = (state_q == BankActive) || (state_q == BankDone) || (state_q == BankPre);
    assign done_o = (state_q == BankDone);
    assign iid_o  = iid_q;
    assign cost_o = cost_q;

endmodule

// File: rtl/simmem_bank_timing_model.sv
// Multi-bank DRAM timing model: address decode, per-bank trackers and completion arbiter.
module simmem_bank_timing_model
    import simmem_bank_timing_model_pkg::*;
#(
    parameter int NumBanks       = DefNumBanks,
    parameter int AddrW          = GlobalMemCapaW,
    parameter int RowBufLenW     = DefRowBufLenW,
    parameter int IidW           = RDataBankAddrW,
    parameter int RowHitCost     = DefRowHitCost,
    parameter int PrechargeCost  = DefPrechargeCost,
    parameter int ActivationCost = DefActivationCost,
    parameter int DelayWidth     = DefDelayWidth,
    parameter int ClosedPage     = 0
) (
    input logic                       clk_i,
    input logic                       rst_i,
    simmem_bank_timing_model_if.slave bus
);

    localparam int BankBits = $clog2(NumBanks);
    localparam int BankIdxW = (BankBits > 0) ? BankBits : 1;
    localparam int RowW     = AddrW - RowBufLenW - BankBits;

    if (PrechargeCost + ActivationCost + RowHitCost > (2 ** DelayWidth) - 1) begin : genCostTooWide
        $error("worst-case access cost does not fit in DelayWidth");
    end
    if (RowHitCost < 1) begin : genHitCostZero
        $error("RowHitCost must be at least 1");
    end
    if (NumBanks < 1 || (NumBanks & (NumBanks - 1)) != 0) begin : genBanksNotPow2
        $error("NumBanks must be a power of two");
    end
    if (RowW < 1) begin : genNoRowBits
        $error("address leaves no row bits");
    end

    logic [BankIdxW-1:0]   reqBank;
    logic [RowW-1:0]       reqRow;
    logic                  reqAccept;
    logic                  unusedAddrBits;
    logic [NumBanks-1:0]   bankIdle;
    logic [NumBanks-1:0]   bankBusy;
    logic [NumBanks-1:0]   bankDone;
    logic [NumBanks-1:0]   bankAccept;
    logic [NumBanks-1:0]   bankPop;
    logic [IidW-1:0]       bankIid  [NumBanks];
    logic [DelayWidth-1:0] bankCost [NumBanks];
    logic                  anyDone;
    logic [BankIdxW-1:0]   lowBank;
    logic [BankIdxW-1:0]   selBank;
    logic                  donePop;
    logic                  lockValid_q, lockValid_d;
    logic [BankIdxW-1:0]   lockBank_q, lockBank_d;

    if (NumBanks > 1) begin : genBankDecode
        assign reqBank = bus.req_addr_i[RowBufLenW +: BankBits];
    end else begin : genSingleBank
        assign reqBank = '0;
    end
    assign reqRow         = bus.req_addr_i[AddrW-1 -: RowW];
    assign unusedAddrBits = ^bus.req_addr_i[RowBufLenW-1:0];

    assign bus.req_ready_o = bankIdle[reqBank];
    assign reqAccept       = bus.req_valid_i && bus.req_ready_o;

    // Steer the accepted request and the completion pop to a single bank each
    always_comb begin
        bankAccept = '0;
        bankPop    = '0;
        for (int b = 0; b < NumBanks; b++) begin
            bankAccept[b] = reqAccept && (reqBank == BankIdxW'(b));
            bankPop[b]    = donePop && (selBank == BankIdxW'(b));
        end
    end

    for (genvar b = 0; b < NumBanks; b++) begin : genBank
        simmem_bank_timing_model_tracker #(
            .RowW           (RowW),
            .IidW           (IidW),
            .RowHitCost     (RowHitCost),
            .PrechargeCost  (PrechargeCost),
            .ActivationCost (ActivationCost),
            .DelayWidth     (DelayWidth),
            .ClosedPage     (ClosedPage)
        ) uTracker (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .accept_i (bankAccept[b]),
            .row_i    (reqRow),
            .iid_i    (bus.req_iid_i),
            .pop_i    (bankPop[b]),
            .idle_o   (bankIdle[b]),
            .busy_o   (bankBusy[b]),
            .done_o   (bankDone[b]),
            .iid_o    (bankIid[b]),
            .cost_o   (bankCost[b])
        );
    end

    // Lowest pending bank wins, unless a stalled winner is already being presented
    always_comb begin
        anyDone = |bankDone;
        lowBank = '0;
        for (int b = NumBanks - 1; b >= 0; b--) begin
            if (bankDone[b]) begin
                lowBank = BankIdxW'(b);
            end
        end
        selBank     = lockValid_q ? lockBank_q : lowBank;
        donePop     = anyDone && bus.done_ready_i;
        lockValid_d = anyDone && !bus.done_ready_i;
        lockBank_d  = selBank;
    end

    // Remember the presented bank while the consumer stalls so the outputs stay put
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lockValid_q <= 1'b0;
            lockBank_q  <= '0;
        end else begin
            lockValid_q <= lockValid_d;
            lockBank_q  <= lockBank_d;
        end
    end

    assign bus.done_valid_o = anyDone;
    assign bus.done_iid_o   = anyDone ? bankIid[selBank] : '0;
    assign bus.done_delay_o = anyDone ? bankCost[selBank] : '0;
    assign bus.bank_busy_o  = bankBusy;

endmodule
